uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit, each held PRESCALE clocks.
// The parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_end_c;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] shreg_nxt_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_par_c;
  assign unused_par_c = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  assign bit_end_c   = (cnt == CNT_LAST);
  assign shreg_nxt_c = shreg >> 1;
  // A new byte is taken when idle or on the final stop clock (back-to-back frames).
  assign accept_c    = bus.DATA_VALID && ((state == IDLE) || ((state == STOP) && bit_end_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (accept_c) begin
      state     <= START;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= bus.P_DATA;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= bus.PAR_EN;
      par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
    end else if (state != IDLE) begin
      cnt <= bit_end_c ? '0 : cnt + CNT_W'(1);
      if (bit_end_c) begin
        case (state)
          START: begin
            state <= DATA;
            idx   <= '0;
            tx_q  <= shreg[0];
          end
          DATA: begin
            // Data leaves LSB first by shifting the latched byte right.
            if (idx != IDX_LAST) begin
              idx   <= idx + IDX_W'(1);
              shreg <= shreg_nxt_c;
              tx_q  <= shreg_nxt_c[0];
            end
`ifdef UART_TX_PARITY_EN
            else if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit_q;
            end
`endif
            else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
`endif
          default: begin
            state  <= IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: randomized strobes against a frame-level reference model, scoreboard monitors decode the line.
module tb_uart_tx;
  localparam int unsigned DW = 8;
  localparam int unsigned P8 = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    bit            par;
    bit            par_bit;
    bit            b2b;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_tx_if #(.DATA_WIDTH(DW)) ifc8 ();
  uart_tx_if #(.DATA_WIDTH(DW)) ifc1 ();

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE(P8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8.slave));
  uart_tx #(.DATA_WIDTH(DW), .PRESCALE(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Parity bit chosen so the total count of ones (data + parity) is even or odd.
  function automatic bit parity_of(input logic [DW-1:0] d, input bit odd);
    int ones = $countones(d);
    return odd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Bit sequence of one frame, first bit on the line at index 0; returns bit count.
  function automatic int frame_vec(input logic [DW-1:0] d, input bit par, input bit pb,
                                   output logic [31:0] v);
    int n;
    v    = '0;
    v[0] = 1'b0;
    for (int i = 0; i < int'(DW); i++) v[1+i] = d[i];
    n = 1 + int'(DW);
    if (par) begin
      v[n] = pb;
      n++;
    end
    v[n] = 1'b1;
    return n + 1;
  endfunction

  // ---------------- reference model / stimulus ----------------
  frame_t     exp_q[$];
  logic [1:0] exp1_q[$];
  int         edge_n  = 0;
  int         free_at = 0;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Present inputs for the next edge; the model decides whether that edge accepts.
  task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit pe, input bit pt);
    int     e;
    frame_t f;
    ifc8.DATA_VALID = v;
    ifc8.P_DATA     = d;
    ifc8.PAR_EN     = pe;
    ifc8.PAR_TYP    = pt;
    e = edge_n + 1;
    if (v && e >= free_at) begin
      f.data    = d;
      f.par     = pe && PAR_ON;
      f.par_bit = parity_of(d, pt);
      f.b2b     = (e == free_at);
      exp_q.push_back(f);
      free_at = e + (2 + int'(DW) + (f.par ? 1 : 0)) * int'(P8);
    end
    tick();
  endtask

  task automatic send_p1(input logic [DW-1:0] d, input bit pe, input bit pt);
    logic [31:0] v;
    int          n;
    n = frame_vec(d, pe && PAR_ON, parity_of(d, pt), v);
    for (int i = 0; i < n; i++) exp1_q.push_back({1'b1, v[i]});
    exp1_q.push_back(2'b01);
    exp1_q.push_back(2'b01);
    ifc1.P_DATA     = d;
    ifc1.PAR_EN     = pe;
    ifc1.PAR_TYP    = pt;
    ifc1.DATA_VALID = 1'b1;
    tick();
    ifc1.DATA_VALID = 1'b0;
    ifc1.P_DATA     = ~d;
    repeat (n + 6) tick();
  endtask

  // ---------------- PRESCALE=8 frame monitor ----------------
  frame_t cur;
  bit     in_frame  = 1'b0;
  bit     skip_busy = 1'b0;
  int     gap  = 1000;
  int     pos  = 0;
  int     flen = 0;
  logic   line_s [0:127];
  logic   busy_s [0:127];

  task automatic finish_frame();
    logic [31:0]   ev;
    logic [31:0]   gv;
    logic [DW-1:0] gd;
    int            n;
    int            bad_hold = 0;
    int            no_busy  = 0;
    n  = frame_vec(cur.data, cur.par, cur.par_bit, ev);
    gv = '0;
    for (int s = 0; s < n; s++) begin
      gv[s] = line_s[s * int'(P8) + int'(P8) / 2];
      for (int k = 0; k < int'(P8); k++)
        if (line_s[s * int'(P8) + k] !== gv[s]) bad_hold++;
    end
    for (int i = 0; i < flen; i++) if (busy_s[i] !== 1'b1) no_busy++;
    gd = gv[DW:1];
    check("frame_data", 32'(gd), 32'(cur.data));
    check("frame_bits", gv, ev);
    check("bit_hold", 32'(bad_hold), 32'd0);
    check("busy_in_frame", 32'(no_busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      skip_busy = 1'b0;
      gap       = 1000;
    end else if (in_frame) begin
      line_s[pos] = ifc8.TX_OUT;
      busy_s[pos] = ifc8.busy;
      pos++;
      if (pos == flen) begin
        finish_frame();
        in_frame = 1'b0;
        gap      = 0;
      end
    end else if (skip_busy) begin
      if (!ifc8.busy) skip_busy = 1'b0;
    end else if (ifc8.busy) begin
      if (exp_q.size() == 0) begin
        check("spurious_frame_busy", 32'(ifc8.busy), 32'd0);
        skip_busy = 1'b1;
      end else begin
        cur = exp_q.pop_front();
        check("b2b_gap", 32'(gap == 0), 32'(cur.b2b));
        flen      = (2 + int'(DW) + (cur.par ? 1 : 0)) * int'(P8);
        line_s[0] = ifc8.TX_OUT;
        busy_s[0] = ifc8.busy;
        pos       = 1;
        in_frame  = 1'b1;
      end
    end else begin
      check("idle_line", 32'(ifc8.TX_OUT), 32'd1);
      gap++;
    end
  end

  // ---------------- PRESCALE=1 cycle monitor ----------------
  bit         m1_run = 1'b0;
  logic [1:0] m1_item;

  always @(negedge clk) begin
    if (rst_n && (ifc1.busy || m1_run) && exp1_q.size() > 0) begin
      m1_run  = 1'b1;
      m1_item = exp1_q.pop_front();
      check("p1_line", 32'(ifc1.TX_OUT), 32'(m1_item[0]));
      check("p1_busy", 32'(ifc1.busy), 32'(m1_item[1]));
      if (exp1_q.size() == 0) m1_run = 1'b0;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int target;
    int thr;
    ifc8.DATA_VALID = 1'b0; ifc8.P_DATA = '0; ifc8.PAR_EN = 1'b0; ifc8.PAR_TYP = 1'b0;
    ifc1.DATA_VALID = 1'b0; ifc1.P_DATA = '0; ifc1.PAR_EN = 1'b0; ifc1.PAR_TYP = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_out", 32'(ifc8.TX_OUT), 32'd1);
    check("rst_busy", 32'(ifc8.busy), 32'd0);
    check("rst_tx_out_p1", 32'(ifc1.TX_OUT), 32'd1);
    repeat (3) tick();
    #2 rst_n = 1'b1;

    repeat (100) drive_cycle(1'b0, '0, 1'b0, 1'b0);

    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h07, 1'b1, 1'b0);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Valid held high: 0x0F waits and is taken on the final stop edge of 0x55.
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
    target = free_at;
    while (edge_n + 1 <= target) drive_cycle(1'b1, 8'h0F, 1'b0, 1'b0);
    repeat (120) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Strobes during a frame's data phase must be dropped.
    drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (20) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (10) drive_cycle(1'b0, 8'hFF, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (20) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst_pre_busy", 32'(ifc8.busy), 32'd1);
    check("midrst_pre_line", 32'(ifc8.TX_OUT), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_out", 32'(ifc8.TX_OUT), 32'd1);
    check("midrst_busy", 32'(ifc8.busy), 32'd0);
    free_at = 0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (50) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    send_p1(8'h80, 1'b0, 1'b0);
    send_p1(8'h3C, 1'b1, 1'b1);

    for (int blk = 0; blk < 4; blk++) begin
      thr = (blk % 2 == 0) ? 3 : 40;
      repeat (1000)
        drive_cycle($urandom_range(0, 99) < thr, DW'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (200) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("p1_q_drained", 32'(exp1_q.size()), 32'd0);
    check("end_busy", 32'(ifc8.busy), 32'd0);
    check("end_line", 32'(ifc8.TX_OUT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
